data_memory_ctrl: RTL and testbench

DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_bank.sv | 78 +++++++
 rtl/data_memory_ctrl.sv | 111 +++++++++++
 tb/tb_data_memory_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and default geometry for the data memory controller and its storage bank.
package dmem_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 16;
  localparam int DEPTH_DEF  = 512;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_bank.sv
// Word storage with byte-enabled writes and a registered read port that also holds the response word.
// Optional per-byte even parity is compiled in with DATA_MEMORY_CTRL_PARITY_EN.
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int IDX_W  = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [IDX_W-1:0]      addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  rd_en,
  input  logic                  rd_clr,
  output logic [DATA_W-1:0]     rdata,
  output logic                  perr
);

  localparam int BE_W = DATA_W / 8;

  // Contents start at zero and are deliberately left alone by rst.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < BE_W; k++) begin
        if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  // Output register doubles as the held response word: loaded on a read, cleared on write/error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[addr];
    end else if (rd_clr) begin
      rdata <= '0;
    end
  end

`ifdef DATA_MEMORY_CTRL_PARITY_EN
  logic [BE_W-1:0] par [DEPTH] = '{default: '0};
  logic [BE_W-1:0] rd_par;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < BE_W; k++) begin
        if (be[k]) par[addr][k] <= ^wdata[8*k +: 8];
      end
    end
  end

  always_comb begin
    rd_par = '0;
    for (int k = 0; k < BE_W; k++) begin
      rd_par[k] = ^mem[addr][8*k +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perr <= 1'b0;
    end else if (rd_en) begin
      perr <= |(rd_par ^ par[addr]);
    end else if (rd_clr) begin
      perr <= 1'b0;
    end
  end
`else
  assign perr = 1'b0;
`endif

endmodule

// File: rtl/data_memory_ctrl.sv
// Single-request data memory controller: IDLE -> ACCESS -> RESP handshake FSM around dmem_bank.
// Build with DATA_MEMORY_CTRL_PARITY_EN to enable per-byte parity checking on reads.
//
// Handshake: a request transfers on a rising edge with req_valid && req_ready (req_ready only in
// IDLE); a response transfers on a rising edge with rsp_valid && rsp_ready, and rsp_* hold until then.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                parity_err,
  output state_t              fsm_state
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t state, state_nxt;

  logic                cap_write;
  logic [ADDR_W-1:0]   cap_addr;
  logic [DATA_W-1:0]   cap_wdata;
  logic [BE_W-1:0]     cap_be;
  logic                in_range;
  logic                do_write;
  logic                do_read;
  logic                do_clr;

  assign fsm_state = state;
  assign in_range  = ({1'b0, cap_addr} < (ADDR_W + 1)'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ACCESS;
      end
      ACCESS: state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are only sampled on acceptance, so req_* are don't-care outside IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
    end else if (state == IDLE && req_valid) begin
      cap_write <= req_write;
      cap_addr  <= req_addr;
      cap_wdata <= req_wdata;
      cap_be    <= req_be;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  rsp_err <= 1'b0;
    else if (state == ACCESS) rsp_err <= !in_range;
  end

  // Gated by state so an async reset during ACCESS drops the commit before the next edge.
  assign do_write = (state == ACCESS) &&  cap_write && in_range;
  assign do_read  = (state == ACCESS) && !cap_write && in_range;
  assign do_clr   = (state == ACCESS) && (cap_write || !in_range);

  dmem_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_bank (
    .clk    (clk),
    .rst    (rst),
    .we     (do_write),
    .be     (cap_be),
    .addr   (cap_addr[IDX_W-1:0]),
    .wdata  (cap_wdata),
    .rd_en  (do_read),
    .rd_clr (do_clr),
    .rdata  (rsp_rdata),
    .perr   (parity_err)
  );

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed plus randomized checks of data_memory_ctrl against a word-array reference model.
module tb_data_memory_ctrl;
  import dmem_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 512;
  localparam int BE_W   = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              parity_err;
  state_t            fsm_state;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [DATA_W-1:0] exp_q[$];
  logic              exp_err_q[$];
  logic              exp_perr_q[$];
  logic [DATA_W-1:0] got;

  data_memory_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .parity_err (parity_err),
    .fsm_state  (fsm_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a plain word array, updated per byte lane.
  task automatic model_req(input logic w, input int addr, input logic [DATA_W-1:0] wdata,
                           input logic [BE_W-1:0] be, input logic exp_perr);
    logic [DATA_W-1:0] word;
    if (addr >= DEPTH) begin
      exp_q.push_back('0);
      exp_err_q.push_back(1'b1);
      exp_perr_q.push_back(1'b0);
    end else if (w) begin
      word = model_mem[addr];
      for (int k = 0; k < BE_W; k++) begin
        if (be[k]) word[8*k +: 8] = wdata[8*k +: 8];
      end
      model_mem[addr] = word;
      exp_q.push_back('0);
      exp_err_q.push_back(1'b0);
      exp_perr_q.push_back(1'b0);
    end else begin
      exp_q.push_back(model_mem[addr]);
      exp_err_q.push_back(1'b0);
      exp_perr_q.push_back(exp_perr);
    end
  endtask

  // Driver: one request, response checked for latency, hold stability and consume.
  task automatic transact(input logic w, input int addr, input logic [DATA_W-1:0] wdata,
                          input logic [BE_W-1:0] be, input int hold, input logic exp_perr,
                          output logic [DATA_W-1:0] rdata_out);
    logic [DATA_W-1:0] e_data;
    logic              e_err;
    logic              e_perr;
    model_req(w, addr, wdata, be, exp_perr);
    e_data = exp_q.pop_front();
    e_err  = exp_err_q.pop_front();
    e_perr = exp_perr_q.pop_front();
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = ADDR_W'(addr);
    req_wdata = wdata;
    req_be    = be;
    @(posedge clk);
    #1;
    // Junk on req_* while busy must be ignored.
    req_valid = 1'($urandom_range(0, 1));
    req_write = 1'($urandom);
    req_addr  = ADDR_W'($urandom_range(0, 15));
    req_wdata = $urandom;
    req_be    = BE_W'($urandom);
    @(negedge clk);
    check("access_rsp_valid", rsp_valid, 0);
    check("access_req_ready", req_ready, 0);
    @(posedge clk);
    #1;
    check("rsp_latency", rsp_valid, 1);
    check("rsp_rdata", rsp_rdata, e_data);
    check("rsp_err", rsp_err, e_err);
    check("parity_err", parity_err, e_perr);
    rdata_out = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_rdata", rsp_rdata, e_data);
      check("hold_rsp_err", rsp_err, e_err);
      check("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("consumed_rsp_valid", rsp_valid, 0);
    check("consumed_req_ready", req_ready, 1);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_state", fsm_state, IDLE);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 1);

    // Full-word write then read back
    transact(1'b1, 5, 32'h1234_5678, 4'hF, 0, 1'b0, got);
    transact(1'b0, 5, '0, '0, 0, 1'b0, got);
    check("read_addr5", got, 32'h1234_5678);

    // Partial byte-enable merge
    transact(1'b1, 7, 32'hAABB_CCDD, 4'hF, 0, 1'b0, got);
    transact(1'b1, 7, 32'h1122_3344, 4'h5, 0, 1'b0, got);
    transact(1'b0, 7, '0, '0, 0, 1'b0, got);
    check("be_merge", got, 32'hAA22_CC44);

    // be == 0 write is a no-op ack
    transact(1'b1, 7, 32'hDEAD_BEEF, 4'h0, 0, 1'b0, got);
    transact(1'b0, 7, '0, '0, 0, 1'b0, got);
    check("be_zero_noop", got, 32'hAA22_CC44);

    // Out-of-range read and write; 600 aliases 88 if truncated
    transact(1'b0, 512, '0, '0, 0, 1'b0, got);
    transact(1'b1, 600, 32'hCAFE_F00D, 4'hF, 0, 1'b0, got);
    transact(1'b0, 88, '0, '0, 0, 1'b0, got);
    check("oor_no_alias", got, 32'h0);

    // Response held under backpressure
    transact(1'b0, 5, '0, '0, 5, 1'b0, got);

    // Reset during ACCESS of a write drops it
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 16'd3;
    req_wdata = 32'hFFFF_FFFF;
    req_be    = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("abort_in_access", fsm_state, ACCESS);
    rst = 1'b1;
    #1;
    check("abort_state", fsm_state, IDLE);
    check("abort_rsp_valid", rsp_valid, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_rsp", rsp_valid, 0);
    end
    transact(1'b0, 3, '0, '0, 0, 1'b0, got);
    check("abort_addr3", got, 32'h0);
    transact(1'b0, 5, '0, '0, 0, 1'b0, got);
    check("mem_kept_after_rst", got, 32'h1234_5678);

`ifdef DATA_MEMORY_CTRL_PARITY_EN
    // Corrupt one stored bit behind the parity's back
    transact(1'b1, 2, 32'h0F0F_0F0F, 4'hF, 0, 1'b0, got);
    @(negedge clk);
    dut.u_bank.mem[2][0] = ~dut.u_bank.mem[2][0];
    model_mem[2][0] = ~model_mem[2][0];
    transact(1'b0, 2, '0, '0, 0, 1'b1, got);
    transact(1'b0, 5, '0, '0, 0, 1'b0, got);
    transact(1'b1, 2, 32'h0F0F_0F0F, 4'hF, 0, 1'b0, got);
    transact(1'b0, 2, '0, '0, 0, 1'b0, got);
`endif

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      int a;
      if ($urandom_range(0, 9) == 0) a = $urandom_range(DEPTH, 700);
      else                           a = $urandom_range(0, 15);
      transact(1'($urandom_range(0, 1)), a, $urandom, BE_W'($urandom),
               $urandom_range(0, 3), 1'b0, got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
